// File: rtl/ram_access_master_if.sv
// Command/response stream plus the RAM strobe bus for ram_access_master.
// master = the initiator's view, slave = the agent and RAM side.
interface ram_access_master_if #(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter int LW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [LW-1:0] cmd_len;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          cmd_done;
   logic          ram_rstn;
   logic          ram_en;
   logic          ram_wr_rdn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_len, rsp_ready, ram_rdata,
      output cmd_ready, rsp_valid, rsp_rdata, cmd_done,
      output ram_rstn, ram_en, ram_wr_rdn, ram_addr, ram_wdata
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_len, rsp_ready, ram_rdata,
      input  cmd_ready, rsp_valid, rsp_rdata, cmd_done,
      input  ram_rstn, ram_en, ram_wr_rdn, ram_addr, ram_wdata
   );
endinterface

// File: rtl/ram_access_master.sv
// Turns valid/ready commands into setup+strobe RAM cycles; write done at +3, read rsp at +3+RD_LATENCY.
// One command in flight; a stalled response freezes the FSM in RESP with no RAM activity.
module ram_access_master #(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int LW         = 4,
   parameter int RD_LATENCY = 1
) (
   input logic                 clk,
   input logic                 rst,
   ram_access_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP} state_t;

   localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic          ram_wr_rdn_q, ram_wr_rdn_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          cmd_done_q, cmd_done_d;
   logic          ram_rstn_q, ram_rstn_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] beat_q, beat_d;
   logic [1:0]    lat_q, lat_d;
   logic          cmd_ready;

   // Held off during the done pulse so a new command starts one cycle later.
   assign cmd_ready = (state_q == IDLE) && !cmd_done_q && !rst;

   always_comb begin
      state_d      = state_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      ram_wr_rdn_d = ram_wr_rdn_q;
      rsp_rdata_d  = rsp_rdata_q;
      cmd_done_d   = 1'b0;
      ram_rstn_d   = !rst;
      len_d        = len_q;
      beat_d       = beat_q;
      lat_d        = lat_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               ram_addr_d   = bus.cmd_addr;
               ram_wr_rdn_d = bus.cmd_wr;
               if (bus.cmd_wr) ram_wdata_d = bus.cmd_wdata;
               len_d   = bus.cmd_len;
               beat_d  = '0;
               state_d = SETUP;
            end
         end
         SETUP: state_d = STROBE;
         STROBE: begin
            lat_d = '0;
            if (ram_wr_rdn_q) begin
               ram_wr_rdn_d = 1'b0;
               cmd_done_d   = 1'b1;
               state_d      = IDLE;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (lat_q == LAT_LAST) begin
               rsp_rdata_d = bus.ram_rdata;
               state_d     = RESP;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               if (beat_q == len_q) begin
                  cmd_done_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  beat_d     = beat_q + 1'b1;
                  ram_addr_d = ram_addr_q + 1'b1;
                  state_d    = SETUP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      ram_rstn_q <= ram_rstn_d;
      if (rst) begin
         state_q      <= IDLE;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         ram_wr_rdn_q <= 1'b0;
         rsp_rdata_q  <= '0;
         cmd_done_q   <= 1'b0;
         len_q        <= '0;
         beat_q       <= '0;
         lat_q        <= '0;
      end else begin
         state_q      <= state_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         ram_wr_rdn_q <= ram_wr_rdn_d;
         rsp_rdata_q  <= rsp_rdata_d;
         cmd_done_q   <= cmd_done_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         lat_q        <= lat_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.cmd_done   = cmd_done_q;
   assign bus.ram_rstn   = ram_rstn_q;
   assign bus.ram_en     = (state_q == STROBE);
   assign bus.ram_wr_rdn = ram_wr_rdn_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_ram_access_master.sv
// Bench for ram_access_master: RD_LATENCY=1 and RD_LATENCY=3 instances, each with a RAM model
// whose read data is only valid in the exact latency cycle.
module tb_ram_access_master;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam logic [DW-1:0] JUNK = 32'hBAD0_BAD0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_access_master_if #(.AW(AW), .DW(DW), .LW(LW)) bus1 ();
   ram_access_master_if #(.AW(AW), .DW(DW), .LW(LW)) bus3 ();

   ram_access_master #(.AW(AW), .DW(DW), .LW(LW), .RD_LATENCY(1)) u_dut (
      .clk(clk), .rst(rst), .bus(bus1));
   ram_access_master #(.AW(AW), .DW(DW), .LW(LW), .RD_LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst), .bus(bus3));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] seed_word(input int i, input int salt);
      return 32'(i * 32'h9E37_79B1) ^ 32'(salt * 32'h5BD1_E995) ^ 32'h1234_5678;
   endfunction

   // RAM models: storage plus a read pipeline that presents data only in the latency cycle.
   logic [DW-1:0] ram1 [1024];
   logic [DW-1:0] ram3 [1024];
   logic          v1 = 1'b0, v3a = 1'b0, v3b = 1'b0, v3c = 1'b0;
   logic [DW-1:0] d1, d3a, d3b, d3c;
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 1024; i++) begin
            ram1[i] <= seed_word(i, 1);
            ram3[i] <= seed_word(i, 3);
         end
      end else begin
         if (bus1.ram_en === 1'b1 && bus1.ram_wr_rdn === 1'b1) ram1[bus1.ram_addr] <= bus1.ram_wdata;
         if (bus3.ram_en === 1'b1 && bus3.ram_wr_rdn === 1'b1) ram3[bus3.ram_addr] <= bus3.ram_wdata;
      end
      v1  <= (bus1.ram_en === 1'b1) && (bus1.ram_wr_rdn === 1'b0);
      d1  <= ram1[bus1.ram_addr];
      v3a <= (bus3.ram_en === 1'b1) && (bus3.ram_wr_rdn === 1'b0);
      d3a <= ram3[bus3.ram_addr];
      v3b <= v3a; d3b <= d3a;
      v3c <= v3b; d3c <= d3b;
   end
   assign bus1.ram_rdata = (v1 === 1'b1) ? d1 : JUNK;
   assign bus3.ram_rdata = (v3c === 1'b1) ? d3c : JUNK;

   // Reference memory contents, updated from the commands the bench issues.
   logic [DW-1:0] mem_ref [1024];

   // Event logs for the RD_LATENCY=1 instance, sampled mid-cycle.
   int            st_cyc[$], rsp_cyc[$], done_cyc[$], hs_cyc[$], rv_cyc[$];
   logic [AW-1:0] st_addr[$];
   logic          st_wr[$];
   logic [DW-1:0] st_wd[$], rsp_dat[$], rv_dat[$];
   int            wrhi_cnt;
   bit            rdy_at[int];

   always @(negedge clk) begin
      #2;
      if (bus1.ram_en === 1'b1) begin
         st_cyc.push_back(cyc); st_addr.push_back(bus1.ram_addr);
         st_wr.push_back(bus1.ram_wr_rdn); st_wd.push_back(bus1.ram_wdata);
      end
      if (bus1.rsp_valid === 1'b1) begin
         rv_cyc.push_back(cyc); rv_dat.push_back(bus1.rsp_rdata);
         if (bus1.rsp_ready === 1'b1) begin
            rsp_cyc.push_back(cyc); rsp_dat.push_back(bus1.rsp_rdata);
         end
      end
      if (bus1.cmd_done === 1'b1) done_cyc.push_back(cyc);
      if (bus1.cmd_valid === 1'b1 && bus1.cmd_ready === 1'b1) hs_cyc.push_back(cyc);
      if (bus1.ram_wr_rdn === 1'b1) wrhi_cnt++;
      rdy_at[cyc] = bus1.cmd_ready;
   end

   task automatic clear_logs();
      st_cyc.delete(); st_addr.delete(); st_wr.delete(); st_wd.delete();
      rsp_cyc.delete(); rsp_dat.delete(); rv_cyc.delete(); rv_dat.delete();
      done_cyc.delete(); hs_cyc.delete(); rdy_at.delete();
      wrhi_cnt = 0;
   endtask

   task automatic issue1(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [LW-1:0] len, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      bus1.cmd_valid = 1'b1; bus1.cmd_wr = wr; bus1.cmd_addr = a;
      bus1.cmd_wdata = wd;   bus1.cmd_len = len;
      for (int i = 0; i < 50; i++) begin
         if (bus1.cmd_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bus1.cmd_valid = 1'b0;
   endtask

   // rmode: 0 = rsp_ready high, 1 = random, 2 = hold low for the first 10 valid cycles.
   task automatic run1(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [LW-1:0] len, input int rmode, output bit ok);
      int stall_n = 0;
      bus1.rsp_ready = 1'b1;
      issue1(wr, a, wd, len, ok);
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if (done_cyc.size() != 0) begin ok = 1'b1; break; end
            if (rmode == 1) bus1.rsp_ready = 1'($urandom_range(0, 1));
            else if (rmode == 2 && bus1.rsp_valid === 1'b1 && stall_n < 10) begin
               bus1.rsp_ready = 1'b0; stall_n++;
            end else bus1.rsp_ready = 1'b1;
            @(negedge clk);
         end
      end
      bus1.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus1.ram_rstn !== 1'b0) begin failures++; $display("FAIL rst_ram_rstn got=%b exp=0", bus1.ram_rstn); end
      checks++; if (bus1.ram_en !== 1'b0) begin failures++; $display("FAIL rst_ram_en got=%b exp=0", bus1.ram_en); end
      checks++; if (bus1.ram_addr !== '0 || bus1.ram_wdata !== '0 || bus1.ram_wr_rdn !== 1'b0) begin
         failures++; $display("FAIL rst_ram_bus got addr=%h wd=%h wr=%b exp=0", bus1.ram_addr, bus1.ram_wdata, bus1.ram_wr_rdn); end
      checks++; if (bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== '0 || bus1.cmd_done !== 1'b0) begin
         failures++; $display("FAIL rst_rsp got vld=%b dat=%h done=%b exp=0", bus1.rsp_valid, bus1.rsp_rdata, bus1.cmd_done); end
      checks++; if (bus1.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", bus1.cmd_ready); end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if (bus1.ram_rstn !== 1'b1 || bus3.ram_rstn !== 1'b1) begin
         failures++; $display("FAIL post_rst_ram_rstn got=%b/%b exp=1", bus1.ram_rstn, bus3.ram_rstn); end
      checks++; if (bus1.cmd_ready !== 1'b1) begin failures++; $display("FAIL post_rst_cmd_ready got=%b exp=1", bus1.cmd_ready); end
   endtask

   task automatic test_single_write();
      bit ok; int h, d;
      clear_logs();
      run1(1'b1, 10'h155, 32'hDEAD_BEEF, 4'd0, 0, ok);
      mem_ref[10'h155] = 32'hDEAD_BEEF;
      checks++; if (!ok) begin failures++; $display("FAIL wr_timeout got=no_done exp=done"); end
      h = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
      checks++; if (st_cyc.size() != 1) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=1", st_cyc.size()); end
      if (st_cyc.size() == 1) begin
         checks++; if (st_cyc[0] != h + 2) begin failures++; $display("FAIL wr_strobe_cycle got=%0d exp=%0d", st_cyc[0], h + 2); end
         checks++; if (st_addr[0] !== 10'h155 || st_wr[0] !== 1'b1 || st_wd[0] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_strobe_bus got a=%h wr=%b wd=%h exp a=155 wr=1 wd=deadbeef", st_addr[0], st_wr[0], st_wd[0]); end
      end
      checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL wr_done_count got=%0d exp=1", done_cyc.size()); end
      d = (done_cyc.size() > 0) ? done_cyc[0] : -100;
      checks++; if (d != h + 3) begin failures++; $display("FAIL wr_done_cycle got=%0d exp=%0d", d, h + 3); end
      checks++; if (rdy_at[d] !== 1'b0 || rdy_at[d + 1] !== 1'b1) begin
         failures++; $display("FAIL wr_ready_after_done got=%b%b exp=01", rdy_at[d], rdy_at[d + 1]); end
   endtask

   task automatic test_single_read();
      bit ok; int h;
      clear_logs();
      run1(1'b0, 10'h155, $urandom, 4'd0, 0, ok);
      h = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
      checks++; if (!ok) begin failures++; $display("FAIL rd_timeout got=no_done exp=done"); end
      checks++; if (st_cyc.size() != 1 || rv_cyc.size() != 1) begin
         failures++; $display("FAIL rd_counts got strobes=%0d valid_cycles=%0d exp=1/1", st_cyc.size(), rv_cyc.size()); end
      if (rsp_cyc.size() == 1) begin
         checks++; if (rsp_cyc[0] != h + 4) begin failures++; $display("FAIL rd_rsp_cycle got=%0d exp=%0d", rsp_cyc[0], h + 4); end
         checks++; if (rsp_dat[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rsp_dat[0]); end
      end else begin
         checks++; failures++; $display("FAIL rd_rsp_count got=%0d exp=1", rsp_cyc.size());
      end
      checks++; if (wrhi_cnt != 0) begin failures++; $display("FAIL rd_wr_rdn_high got=%0d cycles exp=0", wrhi_cnt); end
   endtask

   task automatic test_wrap_burst();
      bit ok; int h; logic [AW-1:0] a;
      clear_logs();
      run1(1'b0, 10'h3FE, '0, 4'd3, 0, ok);
      h = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
      checks++; if (!ok || st_cyc.size() != 4 || rsp_cyc.size() != 4) begin
         failures++; $display("FAIL wrap_counts got ok=%0d strobes=%0d rsps=%0d exp=1/4/4", ok, st_cyc.size(), rsp_cyc.size()); end
      if (st_cyc.size() == 4 && rsp_cyc.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            a = 10'h3FE + 10'(i);
            checks++; if (st_addr[i] !== a) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, st_addr[i], a); end
            checks++; if (rsp_dat[i] !== mem_ref[a]) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", i, rsp_dat[i], mem_ref[a]); end
            checks++; if (st_cyc[i] != ((i == 0) ? h + 2 : rsp_cyc[i - 1] + 2)) begin
               failures++; $display("FAIL wrap_strobe_cycle%0d got=%0d", i, st_cyc[i]); end
         end
      end
      checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", done_cyc.size()); end
   endtask

   task automatic test_backpressure();
      bit ok; int h, d, nrdy; logic [AW-1:0] a;
      a = 10'($urandom_range(0, 1023));
      clear_logs();
      run1(1'b0, a, '0, 4'd1, 2, ok);
      h = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
      d = (done_cyc.size() > 0) ? done_cyc[0] : h + 100;
      checks++; if (!ok || rv_cyc.size() != 12 || rsp_cyc.size() != 2 || st_cyc.size() != 2) begin
         failures++; $display("FAIL bp_counts got ok=%0d valid=%0d rsps=%0d strobes=%0d exp=1/12/2/2",
                              ok, rv_cyc.size(), rsp_cyc.size(), st_cyc.size()); end
      if (rv_cyc.size() == 12 && rsp_cyc.size() == 2 && st_cyc.size() == 2) begin
         for (int i = 0; i < 11; i++) begin
            checks++; if (rv_cyc[i] != rv_cyc[0] + i || rv_dat[i] !== mem_ref[a]) begin
               failures++; $display("FAIL bp_hold%0d got cyc=%0d dat=%h exp cyc=%0d dat=%h", i, rv_cyc[i], rv_dat[i], rv_cyc[0] + i, mem_ref[a]); end
         end
         checks++; if (st_cyc[1] != rsp_cyc[0] + 2) begin failures++; $display("FAIL bp_second_strobe got=%0d exp=%0d", st_cyc[1], rsp_cyc[0] + 2); end
         checks++; if (rsp_dat[1] !== mem_ref[a + 10'd1]) begin failures++; $display("FAIL bp_beat2 got=%h exp=%h", rsp_dat[1], mem_ref[a + 10'd1]); end
      end
      nrdy = 0;
      for (int c = h + 1; c <= d; c++) if (rdy_at[c]) nrdy++;
      checks++; if (nrdy != 0) begin failures++; $display("FAIL bp_cmd_ready got=%0d cycles exp=0", nrdy); end
   endtask

   task automatic test_reset_mid();
      bit ok; int h; logic [AW-1:0] a; logic [DW-1:0] wd;
      a = 10'($urandom_range(0, 1023));
      clear_logs();
      bus1.rsp_ready = 1'b1;
      issue1(1'b0, a, '0, 4'd7, ok);
      for (int i = 0; i < 40 && st_cyc.size() < 2; i++) @(negedge clk);
      checks++; if (st_cyc.size() != 2) begin failures++; $display("FAIL mid_reach_beat2 got strobes=%0d exp=2", st_cyc.size()); end
      rst = 1'b1;
      @(negedge clk); #1;
      checks++; if (bus1.ram_en !== 1'b0 || bus1.rsp_valid !== 1'b0 || bus1.cmd_done !== 1'b0) begin
         failures++; $display("FAIL mid_rst_outputs got en=%b vld=%b done=%b exp=000", bus1.ram_en, bus1.rsp_valid, bus1.cmd_done); end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (done_cyc.size() != 0 || rsp_cyc.size() != 1 || st_cyc.size() != 2) begin
         failures++; $display("FAIL mid_abort got done=%0d rsps=%0d strobes=%0d exp=0/1/2", done_cyc.size(), rsp_cyc.size(), st_cyc.size()); end
      wd = $urandom;
      clear_logs();
      run1(1'b1, 10'h010, wd, 4'($urandom), 0, ok);
      mem_ref[10'h010] = wd;
      h = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
      checks++; if (!ok || st_cyc.size() != 1 || done_cyc.size() != 1) begin
         failures++; $display("FAIL mid_wr_counts got ok=%0d strobes=%0d done=%0d exp=1/1/1", ok, st_cyc.size(), done_cyc.size()); end
      if (st_cyc.size() == 1 && done_cyc.size() == 1) begin
         checks++; if (st_addr[0] !== 10'h010 || st_wd[0] !== wd || done_cyc[0] != h + 3) begin
            failures++; $display("FAIL mid_wr got a=%h wd=%h done=%0d exp a=010 wd=%h done=%0d", st_addr[0], st_wd[0], done_cyc[0], wd, h + 3); end
      end
      clear_logs();
      run1(1'b0, 10'h010, '0, 4'd0, 0, ok);
      checks++; if (rsp_dat.size() != 1 || rsp_dat[0] !== wd) begin
         failures++; $display("FAIL mid_readback got n=%0d exp data=%h", rsp_dat.size(), wd); end
   endtask

   task automatic test_rdlat3();
      int h3, s3, r3; logic [AW-1:0] a; logic [DW-1:0] dat;
      a = 10'($urandom_range(0, 1023));
      h3 = -1; s3 = -1; r3 = -1; dat = '0;
      @(negedge clk);
      bus3.cmd_valid = 1'b1; bus3.cmd_wr = 1'b0; bus3.cmd_addr = a; bus3.cmd_len = '0; bus3.rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus3.cmd_ready === 1'b1) begin h3 = cyc; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bus3.cmd_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (bus3.ram_en === 1'b1 && s3 < 0) s3 = cyc;
         if (bus3.rsp_valid === 1'b1 && r3 < 0) begin r3 = cyc; dat = bus3.rsp_rdata; end
         @(negedge clk);
      end
      checks++; if (h3 < 0 || s3 != h3 + 2) begin failures++; $display("FAIL lat3_strobe got=%0d exp=%0d", s3, h3 + 2); end
      checks++; if (h3 < 0 || r3 != h3 + 6) begin failures++; $display("FAIL lat3_rsp_cycle got=%0d exp=%0d", r3, h3 + 6); end
      checks++; if (dat !== seed_word(int'(a), 3)) begin failures++; $display("FAIL lat3_data got=%h exp=%h", dat, seed_word(int'(a), 3)); end
   endtask

   task automatic test_random();
      bit ok; int h, nb; logic wr; logic [AW-1:0] a, ea; logic [DW-1:0] wd; logic [LW-1:0] len;
      for (int n = 0; n < 40; n++) begin
         wr  = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         a   = 10'($urandom_range(0, 1023));
         wd  = $urandom;
         len = (n == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         clear_logs();
         run1(wr, a, wd, len, int'($urandom_range(0, 1)), ok);
         h  = (hs_cyc.size() > 0) ? hs_cyc[0] : -100;
         nb = wr ? 1 : int'(len) + 1;
         checks++; if (!ok || st_cyc.size() != nb || done_cyc.size() != 1 || (!wr && rsp_cyc.size() != nb)) begin
            failures++; $display("FAIL rnd%0d_counts got ok=%0d strobes=%0d rsps=%0d done=%0d exp strobes=%0d",
                                 n, ok, st_cyc.size(), rsp_cyc.size(), done_cyc.size(), nb); end
         if (wr) begin
            if (st_cyc.size() == 1) begin
               checks++; if (st_addr[0] !== a || st_wr[0] !== 1'b1 || st_wd[0] !== wd || st_cyc[0] != h + 2) begin
                  failures++; $display("FAIL rnd%0d_write got a=%h wd=%h exp a=%h wd=%h", n, st_addr[0], st_wd[0], a, wd); end
            end
            mem_ref[a] = wd;
         end else if (st_cyc.size() == nb && rsp_cyc.size() == nb) begin
            for (int i = 0; i < nb; i++) begin
               ea = a + 10'(i);
               checks++; if (st_addr[i] !== ea || st_wr[i] !== 1'b0 || rsp_dat[i] !== mem_ref[ea]) begin
                  failures++; $display("FAIL rnd%0d_beat%0d got a=%h dat=%h exp a=%h dat=%h", n, i, st_addr[i], rsp_dat[i], ea, mem_ref[ea]); end
               checks++; if (st_cyc[i] != ((i == 0) ? h + 2 : rsp_cyc[i - 1] + 2)) begin
                  failures++; $display("FAIL rnd%0d_beat%0d_timing got=%0d", n, i, st_cyc[i]); end
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem_ref[i] = seed_word(i, 1);
      rst = 1'b1;
      bus1.cmd_valid = 1'b0; bus1.cmd_wr = 1'b0; bus1.cmd_addr = '0; bus1.cmd_wdata = '0;
      bus1.cmd_len = '0; bus1.rsp_ready = 1'b1;
      bus3.cmd_valid = 1'b0; bus3.cmd_wr = 1'b0; bus3.cmd_addr = '0; bus3.cmd_wdata = '0;
      bus3.cmd_len = '0; bus3.rsp_ready = 1'b1;
      test_reset();
      test_single_write();
      test_single_read();
      test_wrap_burst();
      test_backpressure();
      test_reset_mid();
      test_rdlat3();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ram_access_master.md
Name: ram_access_master

Overview:
- Initiator for the team's single-port synchronous RAM (en / wr_rdn / addr / data_wr / data_rd).
- Converts a valid/ready command stream into the RAM's strobe protocol, which is a one-cycle setup followed by a one-cycle en strobe.
- Captures read data and returns it on a valid/ready response port with backpressure.
- Sits between a DMA or CPU-side agent and the RAM instance, and replaces hand-driven task sequences.

Parameters:
AW, 10, RAM address width
DW, 32, RAM data width
LW, 4, burst length field width (max burst = 2^LW words)
RD_LATENCY, 1, cycles from the en-strobe cycle until data_rd is valid (1..3)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  AW  start address
cmd_wdata  in  DW  write data (single beat)
cmd_len  in  LW  read burst beats minus 1; ignored for writes
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer accepts rsp_rdata
rsp_rdata  out  DW  captured read word
cmd_done  out  1  one-cycle pulse when a command fully completes
ram_rstn  out  1  RAM active-low reset, registered
ram_en  out  1  RAM enable strobe
ram_wr_rdn  out  1  RAM 1 = write, 0 = read
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data

Behaviour:
- Reset (rst high at edge) clears everything synchronously:
  - ram_en=0, ram_wr_rdn=0, ram_addr=0, ram_wdata=0.
  - rsp_valid=0, rsp_rdata=0, cmd_done=0, cmd_ready=0 while rst is high.
  - State = IDLE; beat counter = 0.
- ram_rstn is a flop of ~rst: low during reset, high from the first edge after rst deasserts.
- A reset mid-command aborts it: no response, no cmd_done, and ram_en drops at that same edge.
- States are IDLE, SETUP, STROBE, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch cmd_wr, cmd_addr, cmd_wdata and cmd_len, then go to SETUP.
- SETUP (1 cycle):
  - Drive ram_addr, ram_wr_rdn and ram_wdata (for writes); ram_en=0.
  - Go to STROBE.
- STROBE (1 cycle):
  - ram_en=1 with address, data and wr_rdn held stable.
  - Write: next cycle ram_en=0 and ram_wr_rdn=0; cmd_done pulses that same next cycle; go to IDLE.
  - Read: go to CAPTURE.
- CAPTURE (RD_LATENCY cycles):
  - ram_en=0, address held.
  - On the last CAPTURE cycle's edge, register ram_rdata into rsp_rdata; go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata stays stable until the handshake.
  - On rsp_ready, with beats remaining: increment ram_addr modulo 2^AW (0x3FF wraps to 0x000) and go to SETUP.
  - On rsp_ready, last beat: rsp_valid=0, cmd_done pulses the next cycle, go to IDLE.
- cmd_ready=0 in every state except IDLE; commands are never queued.
- Latency, from the cmd handshake edge:
  - Write: ram_en is high in cycle +2; cmd_done in cycle +3.
  - Read (RD_LATENCY=1): rsp_valid rises in cycle +4.
  - Each further burst beat costs 3+RD_LATENCY cycles after the rsp handshake.
- Backpressure: holding rsp_ready low stalls indefinitely with no RAM activity.
- cmd_ready is not asserted in the cycle in which cmd_done pulses; the next command is accepted one cycle later.
- cmd_len=2^LW-1 gives 16 beats with the default LW.

Test Plan:
- Reset then single write: rst 1 for 2 cycles, then cmd wr=1 addr=0x155 wdata=0xDEADBEEF.
  - ram_en high for exactly 1 cycle, 2 cycles after the handshake, with addr=0x155, wr_rdn=1, wdata=0xDEADBEEF.
  - cmd_done pulses the next cycle; ram_rstn=0 during reset and 1 after.
- Single read of the same location, rsp_ready tied 1, RAM model returning the stored data.
  - rsp_valid for 1 cycle with rsp_rdata=0xDEADBEEF, 4 cycles after the handshake; wr_rdn=0 throughout.
- Wrapping burst: read addr=0x3FE, len=3.
  - ram_en strobes at 0x3FE, 0x3FF, 0x000, 0x001.
  - Four responses in order, then a single cmd_done.
- Backpressure: rsp_ready low for 10 cycles during a 2-beat read.
  - rsp_valid and rsp_rdata are held steady.
  - No ram_en and cmd_ready=0 during the stall; the second beat issues only after the handshake.
- Reset mid-burst: assert rst while in CAPTURE of beat 2 of len=7.
  - Next edge: ram_en=0, rsp_valid=0, no cmd_done.
  - After release, a new write at 0x010 completes normally.
- RD_LATENCY=3 build: single read.
  - rsp_rdata is captured exactly 3 cycles after the strobe; rsp_valid rises 6 cycles after the handshake.
